wb_stage: RTL and testbench
===========================

# wb_stage

Writeback stage of the five-stage MIPS core. It consumes the `wb_*` bundle registered by the EX/WB segment and waits on the data-memory response for loads and stores. It aligns and extends load data, selects the result source and issues exactly one register-file write per instruction. It raises a stall request while a memory response is outstanding, and drops responses that belong to flushed instructions.

## Interface
- No parameters.
- `clk`  in  1  core clock.
- `reset`  in  1  asynchronous, active-high reset.
- `stall`  in  1  global stall; when 0 at a rising edge, the EX/WB segment loads a new instruction.
- `refresh`  in  1  exception/eret flush; the EX/WB segment clears at the same edge.
- `wb_pc` / `wb_res` / `wb_cp0rdata` / `wb_hilordata`  in  32 each  segment outputs.
- `wb_load`, `wb_loadX`, `wb_regwen`, `wb_data_req`, `wb_cp0ren`  in  1 each.
- `wb_lsV`  in  4  byte-valid mask.
- `wb_data_addr`  in  2  low address bits.
- `wb_wreg`  in  5  destination register.
- `wb_hiloren`  in  2  nonzero means a HI/LO read.
- `data_data_ok`  in  1  memory response strobe, one per request, in order.
- `data_rdata`  in  32  response data, valid with `data_data_ok`.
- `wb_stall`  out  1  stall request to the pipeline control.
- `rf_wen`  out  1  register-file write enable.
- `rf_waddr`  out  5  register-file write address.
- `rf_wdata`  out  32  register-file write data.
- `debug_wb_pc`  out  32  trace PC.
- `debug_wb_rf_wen`  out  4  trace write enable.
- `debug_wb_rf_wnum`  out  5  trace register number.
- `debug_wb_rf_wdata`  out  32  trace write data.

## Operation
- `valid` = `wb_regwen | wb_data_req`.
- `done` register: set on commit; cleared at any edge where `stall`=0 or `refresh`=1.
- FSM states:
  - **IDLE** — no response expected.
  - **WAIT** — response outstanding for the current instruction.
  - **HOLD** — response consumed; waiting for the segment to advance.
  - **DROP** — one response owed to a flushed instruction.
- Transitions:
  - IDLE, valid, `wb_data_req`, !done → WAIT. A same-cycle `data_data_ok` is accepted in IDLE, and the FSM goes directly to HOLD (or to IDLE if `stall`=0).
  - WAIT, `data_data_ok` → HOLD if `stall`, else IDLE.
  - WAIT, `refresh` without `data_data_ok` → DROP.
  - HOLD, `stall`=0 or `refresh` → IDLE.
  - DROP, `data_data_ok` → IDLE, with no write.
- Commit (single-cycle `rf_wen` pulse):
  - Non-memory valid instruction: first cycle with done=0.
  - Memory instruction: the cycle `data_data_ok` is accepted.
  - `rf_wen` = `wb_regwen` & (`wb_wreg`≠0) & commit & !`refresh`.
  - Stores: commit without writing.
- Result select, in priority order:
  1. `wb_load` → aligned load data.
  2. `wb_cp0ren` → `wb_cp0rdata`.
  3. `wb_hiloren`≠0 → `wb_hilordata`.
  4. Otherwise → `wb_res`, which already carries the link address for AL instructions.
- Load alignment: shift = `data_rdata` >> (8·`wb_data_addr`).
  - `wb_lsV`=0001: byte.
  - `wb_lsV`=0011: halfword.
  - Any other value: full word, unshifted.
  - `wb_loadX`=1: sign-extend. `wb_loadX`=0: zero-extend.
- `wb_stall` = (WAIT & !`data_data_ok`) | (IDLE & valid & `wb_data_req` & !done & !`data_data_ok`) | DROP.
  - DROP stalls so that a new instruction never pairs with a stale response.
- Load data is captured into a 32-bit buffer on acceptance. `rf_wdata` is driven from the buffer only for trace stability; the write itself uses the bypassed value.
- Debug outputs:
  - `debug_wb_pc` = `wb_pc`.
  - `debug_wb_rf_wen` = {4{`rf_wen`}}.
  - `debug_wb_rf_wnum` = `rf_waddr`.
  - `debug_wb_rf_wdata` = `rf_wdata`.

## Timing
- Reset (asynchronous): FSM=IDLE, done=0, buffer=0. All outputs follow combinationally; with a cleared segment, every output is 0.
- Non-memory instruction: write occurs in the cycle it is visible in WB (0-cycle latency).
- Load: write occurs in the cycle of `data_data_ok`. `wb_stall` falls in that same cycle.
- A sustained external `stall` never produces a second write (done=1, HOLD).
- `refresh` coincident with `data_data_ok`: the response is consumed, no write occurs, next state IDLE.
- `refresh` in DROP: the FSM stays in DROP.
- Reset mid-WAIT: the FSM returns to IDLE. The memory side is reset together with this block, so no response is owed.

## Structure
- The shared `cpu_defs` package holds:
  - FSM state encodings (2-bit).
  - `wb_lsV` constants: LS_B=0001, LS_H=0011, LS_W=1111.
- One natural sub-module: `load_align`, a combinational block mapping (`rdata`, `addr`, `lsV`, `loadX`) to 32-bit data.

## Test plan
- ADDU, `wb_regwen`=1, `wb_wreg`=5, `wb_res`=0x1234 → a single `rf_wen` pulse writing 0x00001234 to r5; no stall.
- LB, `wb_data_addr`=2, `wb_loadX`=1, `data_rdata`=0x00800000, `data_data_ok` asserted 3 cycles later:
  - `wb_stall` high for 3 cycles.
  - Then write 0xFFFFFF80.
- LHU, `wb_data_addr`=2, `wb_loadX`=0, `data_rdata`=0xBEEF0000 → write 0x0000BEEF.
- Load completes while `stall` is held for 4 cycles → exactly one write; FSM in HOLD until `stall` drops.
- `refresh` during WAIT, then a new LW enters, then two `data_data_ok` strobes (0xAAAA, 0x5555):
  - First strobe: dropped, no write.
  - Second strobe: 0x5555 written.
- `wb_wreg`=0 with `wb_regwen`=1 → `rf_wen` stays 0. Reset asserted in WAIT → FSM returns to IDLE and all outputs go to 0 asynchronously.

Source files
------------

// File: rtl/cpu_defs.sv
// Shared core definitions: writeback FSM encodings and load/store byte-valid masks.
package cpu_defs;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2,
        ST_DROP = 2'd3
    } wb_state_t;

    localparam logic [3:0] LS_B = 4'b0001;
    localparam logic [3:0] LS_H = 4'b0011;
    localparam logic [3:0] LS_W = 4'b1111;

endpackage

// File: rtl/wb_stage_if.sv
// EX/WB segment bundle plus the data-memory response, as seen by the writeback stage.
interface wb_stage_if;

    logic [31:0] wb_pc;
    logic [31:0] wb_res;
    logic [31:0] wb_cp0rdata;
    logic [31:0] wb_hilordata;
    logic        wb_load;
    logic        wb_loadX;
    logic        wb_regwen;
    logic        wb_data_req;
    logic        wb_cp0ren;
    logic [3:0]  wb_lsV;
    logic [1:0]  wb_data_addr;
    logic [4:0]  wb_wreg;
    logic [1:0]  wb_hiloren;
    logic        data_data_ok;
    logic [31:0] data_rdata;

    modport master (
        output wb_pc, wb_res, wb_cp0rdata, wb_hilordata,
        output wb_load, wb_loadX, wb_regwen, wb_data_req, wb_cp0ren,
        output wb_lsV, wb_data_addr, wb_wreg, wb_hiloren,
        output data_data_ok, data_rdata
    );

    modport slave (
        input wb_pc, wb_res, wb_cp0rdata, wb_hilordata,
        input wb_load, wb_loadX, wb_regwen, wb_data_req, wb_cp0ren,
        input wb_lsV, wb_data_addr, wb_wreg, wb_hiloren,
        input data_data_ok, data_rdata
    );

endinterface

// File: rtl/load_align.sv
// Load data alignment: shifts the addressed byte/halfword down and extends it.
module load_align
    import cpu_defs::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr,
    input  logic [3:0]  lsV,
    input  logic        loadX,
    output logic [31:0] data
);

    logic [31:0] shifted;
    logic signed [7:0]  byte_s;
    logic signed [15:0] half_s;

    assign shifted = rdata >> {addr, 3'b000};
    assign byte_s  = shifted[7:0];
    assign half_s  = shifted[15:0];

    // Pick width by byte-valid mask; extension sign comes from loadX.
    always_comb begin
        data = rdata;
        case (lsV)
            LS_B:    data = {{24{loadX & byte_s[7]}}, byte_s};
            LS_H:    data = {{16{loadX & half_s[15]}}, half_s};
            LS_W:    data = rdata;
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: waits on memory responses, selects the result and issues
// exactly one register-file write per instruction.
module wb_stage
    import cpu_defs::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        refresh,
    wb_stage_if.slave   wb,
    output logic        wb_stall,
    output logic        rf_wen,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic [31:0] debug_wb_pc,
    output logic [3:0]  debug_wb_rf_wen,
    output logic [4:0]  debug_wb_rf_wnum,
    output logic [31:0] debug_wb_rf_wdata
);

    wb_state_t   state, state_nxt;
    logic        done;
    logic [31:0] load_buf;
    logic [31:0] load_data;
    logic [31:0] result;
    logic        valid;
    logic        mem_start;
    logic        accept;
    logic        commit;

    load_align u_load_align (
        .rdata (wb.data_rdata),
        .addr  (wb.wb_data_addr),
        .lsV   (wb.wb_lsV),
        .loadX (wb.wb_loadX),
        .data  (load_data)
    );

    assign valid     = wb.wb_regwen | wb.wb_data_req;
    // A memory instruction that has not yet seen its response.
    assign mem_start = (state == ST_IDLE) & valid & wb.wb_data_req & ~done;
    // Response belonging to the current instruction, including same-cycle hits in IDLE.
    assign accept    = ((state == ST_WAIT) | mem_start) & wb.data_data_ok;
    assign commit    = (valid & ~wb.wb_data_req & ~done) | accept;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic; a flush with a request in flight owes one response.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (mem_start) begin
                    if (wb.data_data_ok) state_nxt = (stall & ~refresh) ? ST_HOLD : ST_IDLE;
                    else if (refresh)    state_nxt = ST_DROP;
                    else                 state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (wb.data_data_ok) state_nxt = (stall & ~refresh) ? ST_HOLD : ST_IDLE;
                else if (refresh)    state_nxt = ST_DROP;
            end
            ST_HOLD: begin
                if (~stall | refresh) state_nxt = ST_IDLE;
            end
            ST_DROP: begin
                if (wb.data_data_ok) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Commit tracker: blocks repeat writes while the segment is held.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                 done <= 1'b0;
        else if (~stall | refresh) done <= 1'b0;
        else if (commit)           done <= 1'b1;
    end

    // Aligned load data captured on acceptance for a stable trace while held.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                   load_buf <= 32'd0;
        else if (accept & wb.wb_load) load_buf <= load_data;
    end

    // Result source select in priority order.
    always_comb begin
        result = wb.wb_res;
        if (wb.wb_load)                result = load_data;
        else if (wb.wb_cp0ren)         result = wb.wb_cp0rdata;
        else if (wb.wb_hiloren != 2'b00) result = wb.wb_hilordata;
    end

    assign wb_stall = ((state == ST_WAIT) & ~wb.data_data_ok)
                    | (mem_start & ~wb.data_data_ok)
                    | (state == ST_DROP);

    assign rf_wen   = wb.wb_regwen & (wb.wb_wreg != 5'd0) & commit & ~refresh;
    assign rf_waddr = wb.wb_wreg;
    assign rf_wdata = ((state == ST_HOLD) & wb.wb_load) ? load_buf : result;

    assign debug_wb_pc       = wb.wb_pc;
    assign debug_wb_rf_wen   = {4{rf_wen}};
    assign debug_wb_rf_wnum  = rf_waddr;
    assign debug_wb_rf_wdata = rf_wdata;

endmodule

// File: tb/tb_wb_stage.sv
// Directed testbench for the writeback stage.
module tb_wb_stage;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        refresh;
    logic        wb_stall;
    logic        rf_wen;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [31:0] debug_wb_pc;
    logic [3:0]  debug_wb_rf_wen;
    logic [4:0]  debug_wb_rf_wnum;
    logic [31:0] debug_wb_rf_wdata;

    int n_checks = 0;
    int n_errors = 0;

    wb_stage_if bus ();

    wb_stage dut (
        .clk               (clk),
        .reset             (reset),
        .stall             (stall),
        .refresh           (refresh),
        .wb                (bus.slave),
        .wb_stall          (wb_stall),
        .rf_wen            (rf_wen),
        .rf_waddr          (rf_waddr),
        .rf_wdata          (rf_wdata),
        .debug_wb_pc       (debug_wb_pc),
        .debug_wb_rf_wen   (debug_wb_rf_wen),
        .debug_wb_rf_wnum  (debug_wb_rf_wnum),
        .debug_wb_rf_wdata (debug_wb_rf_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic bubble();
        bus.wb_pc        = 32'd0;
        bus.wb_res       = 32'd0;
        bus.wb_cp0rdata  = 32'd0;
        bus.wb_hilordata = 32'd0;
        bus.wb_load      = 1'b0;
        bus.wb_loadX     = 1'b0;
        bus.wb_regwen    = 1'b0;
        bus.wb_data_req  = 1'b0;
        bus.wb_cp0ren    = 1'b0;
        bus.wb_lsV       = 4'd0;
        bus.wb_data_addr = 2'd0;
        bus.wb_wreg      = 5'd0;
        bus.wb_hiloren   = 2'd0;
        bus.data_data_ok = 1'b0;
        bus.data_rdata   = 32'd0;
    endtask

    task automatic load(input logic [31:0] pc, input logic [4:0] rd, input logic [3:0] lsv,
                        input logic [1:0] a, input logic sx);
        bubble();
        bus.wb_pc        = pc;
        bus.wb_load      = 1'b1;
        bus.wb_regwen    = 1'b1;
        bus.wb_data_req  = 1'b1;
        bus.wb_lsV       = lsv;
        bus.wb_data_addr = a;
        bus.wb_loadX     = sx;
        bus.wb_wreg      = rd;
    endtask

    int writes;

    initial begin
        reset   = 1'b1;
        stall   = 1'b0;
        refresh = 1'b0;
        bubble();
        #12;
        // reset state
        chk("rst_wen", {31'd0, rf_wen}, 32'd0);
        chk("rst_stall", {31'd0, wb_stall}, 32'd0);
        chk("rst_wdata", rf_wdata, 32'd0);
        chk("rst_pc", debug_wb_pc, 32'd0);
        chk("rst_dwen", {28'd0, debug_wb_rf_wen}, 32'd0);
        tick();
        reset = 1'b0;
        tick();

        // ADDU r5 = 0x1234, segment held one extra cycle
        bubble();
        bus.wb_pc = 32'hBFC0_0100; bus.wb_regwen = 1'b1; bus.wb_wreg = 5'd5; bus.wb_res = 32'h1234;
        stall = 1'b1;
        settle();
        chk("addu_wen", {31'd0, rf_wen}, 32'd1);
        chk("addu_waddr", {27'd0, rf_waddr}, 32'd5);
        chk("addu_wdata", rf_wdata, 32'h0000_1234);
        chk("addu_stall", {31'd0, wb_stall}, 32'd0);
        chk("addu_dwen", {28'd0, debug_wb_rf_wen}, 32'hF);
        chk("addu_dpc", debug_wb_pc, 32'hBFC0_0100);
        tick();
        settle();
        chk("addu_once", {31'd0, rf_wen}, 32'd0);
        stall = 1'b0;
        tick();
        bubble();

        // LB with response three cycles later
        load(32'hBFC0_0104, 5'd7, 4'b0001, 2'd2, 1'b1);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk($sformatf("lb_stall%0d", i), {31'd0, wb_stall}, 32'd1);
            chk($sformatf("lb_nowen%0d", i), {31'd0, rf_wen}, 32'd0);
            tick();
        end
        bus.data_data_ok = 1'b1; bus.data_rdata = 32'h0080_0000;
        stall = 1'b0;
        settle();
        chk("lb_stall_fall", {31'd0, wb_stall}, 32'd0);
        chk("lb_wen", {31'd0, rf_wen}, 32'd1);
        chk("lb_wdata", rf_wdata, 32'hFFFF_FF80);
        chk("lb_dwnum", {27'd0, debug_wb_rf_wnum}, 32'd7);
        tick();
        bubble();
        settle();
        chk("lb_after_stall", {31'd0, wb_stall}, 32'd0);
        tick();

        // LHU with a same-cycle response
        load(32'hBFC0_0108, 5'd8, 4'b0011, 2'd2, 1'b0);
        bus.data_data_ok = 1'b1; bus.data_rdata = 32'hBEEF_0000;
        settle();
        chk("lhu_wen", {31'd0, rf_wen}, 32'd1);
        chk("lhu_wdata", rf_wdata, 32'h0000_BEEF);
        chk("lhu_stall", {31'd0, wb_stall}, 32'd0);
        tick();
        bubble();
        tick();

        // LW completing while stall is held four cycles
        load(32'hBFC0_010C, 5'd9, 4'b1111, 2'd0, 1'b0);
        stall = 1'b1;
        writes = 0;
        settle();
        chk("lw_hold_req", {31'd0, wb_stall}, 32'd1);
        tick();
        bus.data_data_ok = 1'b1; bus.data_rdata = 32'hCAFE_F00D;
        settle();
        chk("lw_hold_wdata", rf_wdata, 32'hCAFE_F00D);
        writes += int'(rf_wen);
        for (int i = 0; i < 4; i++) begin
            tick();
            bus.data_data_ok = 1'b0; bus.data_rdata = 32'd0;
            if (i == 3) stall = 1'b0;
            settle();
            writes += int'(rf_wen);
            chk($sformatf("lw_hold_stall%0d", i), {31'd0, wb_stall}, 32'd0);
            chk($sformatf("lw_hold_buf%0d", i), rf_wdata, 32'hCAFE_F00D);
        end
        chk("lw_hold_writes", writes, 32'd1);
        tick();
        bubble();
        tick();

        // refresh in WAIT, new LW, stale then real response
        load(32'hBFC0_0110, 5'd10, 4'b1111, 2'd0, 1'b0);
        stall = 1'b1;
        tick();
        refresh = 1'b1;
        settle();
        chk("flush_wait_stall", {31'd0, wb_stall}, 32'd1);
        chk("flush_wait_wen", {31'd0, rf_wen}, 32'd0);
        tick();
        refresh = 1'b0;
        load(32'hBFC0_0200, 5'd11, 4'b1111, 2'd0, 1'b0);
        settle();
        chk("drop_stall", {31'd0, wb_stall}, 32'd1);
        chk("drop_wen", {31'd0, rf_wen}, 32'd0);
        tick();
        bus.data_data_ok = 1'b1; bus.data_rdata = 32'h0000_AAAA;
        settle();
        chk("drop_strobe_wen", {31'd0, rf_wen}, 32'd0);
        chk("drop_strobe_stall", {31'd0, wb_stall}, 32'd1);
        tick();
        bus.data_data_ok = 1'b0; bus.data_rdata = 32'd0;
        settle();
        chk("newlw_req", {31'd0, wb_stall}, 32'd1);
        chk("newlw_nowen", {31'd0, rf_wen}, 32'd0);
        tick();
        bus.data_data_ok = 1'b1; bus.data_rdata = 32'h0000_5555;
        stall = 1'b0;
        settle();
        chk("newlw_wen", {31'd0, rf_wen}, 32'd1);
        chk("newlw_waddr", {27'd0, rf_waddr}, 32'd11);
        chk("newlw_wdata", rf_wdata, 32'h0000_5555);
        tick();
        bubble();
        tick();

        // refresh coincident with the response
        load(32'hBFC0_0114, 5'd12, 4'b1111, 2'd0, 1'b0);
        stall = 1'b1;
        tick();
        bus.data_data_ok = 1'b1; bus.data_rdata = 32'h0000_0001;
        refresh = 1'b1;
        settle();
        chk("flush_ok_wen", {31'd0, rf_wen}, 32'd0);
        chk("flush_ok_stall", {31'd0, wb_stall}, 32'd0);
        tick();
        refresh = 1'b0;
        stall = 1'b0;
        bubble();
        settle();
        chk("flush_ok_idle", {31'd0, wb_stall}, 32'd0);
        tick();

        // write to r0 suppressed
        bubble();
        bus.wb_regwen = 1'b1; bus.wb_wreg = 5'd0; bus.wb_res = 32'h77;
        settle();
        chk("r0_wen", {31'd0, rf_wen}, 32'd0);
        chk("r0_dwen", {28'd0, debug_wb_rf_wen}, 32'd0);
        tick();
        bubble();
        tick();

        // asynchronous reset while waiting on a load
        load(32'hBFC0_0118, 5'd13, 4'b1111, 2'd0, 1'b0);
        stall = 1'b1;
        tick();
        settle();
        chk("rstw_pre_stall", {31'd0, wb_stall}, 32'd1);
        #1;
        reset = 1'b1;
        bubble();
        stall = 1'b0;
        #1;
        chk("rstw_stall", {31'd0, wb_stall}, 32'd0);
        chk("rstw_wen", {31'd0, rf_wen}, 32'd0);
        chk("rstw_wdata", rf_wdata, 32'd0);
        chk("rstw_pc", debug_wb_pc, 32'd0);
        tick();
        reset = 1'b0;
        tick();
        bubble();
        bus.wb_regwen = 1'b1; bus.wb_wreg = 5'd3; bus.wb_res = 32'h0000_00AB;
        settle();
        chk("post_rst_wen", {31'd0, rf_wen}, 32'd1);
        chk("post_rst_wdata", rf_wdata, 32'h0000_00AB);
        tick();
        bubble();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
